// File: rtl/axil_rd_arb_pkg.sv
// Shared types and constants for the AXI4-Lite read arbiter and its round-robin helper.
// The optional data-phase timeout is enabled with the AXIL_RD_TIMEOUT_EN macro.
package axil_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    // Index width for a grant number; never narrower than one bit.
    function automatic int clog2_m(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or above the pointer, wrapping.
// Produces both a one-hot grant and the binary index of the winner.
module rr_arbiter
    import axil_rd_arb_pkg::*;
#(
    parameter int NUM_M = 2,
    localparam int IDX_W = clog2_m(NUM_M)
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NUM_M-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan NUM_M positions starting at the pointer; the first hit wins.
    always_comb begin
        int k;
        k       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            k = int'(i_ptr) + i;
            if (k >= NUM_M) begin
                k = k - NUM_M;
            end
            if (!o_valid && i_req[k]) begin
                o_valid    = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/axil_read_arbiter.sv
// Shares one AXI4-Lite read slave port among NUM_M masters, one outstanding read at a time.
// Define AXIL_RD_TIMEOUT_EN to add the data-phase timeout with SLVERR and DRAIN recovery.
module axil_read_arbiter
    import axil_rd_arb_pkg::*;
#(
    parameter int NUM_M          = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [NUM_M-1:0]        s_arvalid,
    input  logic [NUM_M*ADDR_W-1:0] s_araddr,
    output logic [NUM_M-1:0]        s_arready,
    output logic [NUM_M-1:0]        s_rvalid,
    input  logic [NUM_M-1:0]        s_rready,
    output logic [DATA_W-1:0]       s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    m_arvalid,
    output logic [ADDR_W-1:0]       m_araddr,
    input  logic                    m_arready,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic [1:0]              m_rresp
);

    localparam int IDX_W = clog2_m(NUM_M);

    state_t             r_state;
    state_t             w_nextState;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_nextPtr;
    logic [IDX_W-1:0]   w_arbIdx;
    logic [NUM_M-1:0]   w_arbGrant;
    logic               w_arbValid;
    logic               w_release;
    logic [ADDR_W-1:0]  r_araddr;
    logic [ADDR_W-1:0]  w_selAddr;
    logic               w_timedOut;

    rr_arbiter #(
        .NUM_M (NUM_M)
    ) u_rrArbiter (
        .i_req   (s_arvalid),
        .i_ptr   (r_ptr),
        .o_grant (w_arbGrant),
        .o_idx   (w_arbIdx),
        .o_valid (w_arbValid)
    );

    always_comb begin
        w_selAddr = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (w_arbGrant[i]) begin
                w_selAddr = w_selAddr | s_araddr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_nextPtr = (r_grant == IDX_W'(NUM_M - 1)) ? '0 : r_grant + 1'b1;
    assign m_araddr  = r_araddr;

`ifdef AXIL_RD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_toCount;

    assign w_timedOut = (r_state == DATA) && (r_toCount == CNT_W'(TIMEOUT_CYCLES));

    // Counter sits at zero outside DATA and saturates once the limit is reached.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_toCount <= '0;
        end else if (r_state != DATA) begin
            r_toCount <= '0;
        end else if (!(m_rvalid && m_rready) && !w_timedOut) begin
            r_toCount <= r_toCount + 1'b1;
        end
    end
`else
    assign w_timedOut = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_ptr    <= '0;
            r_araddr <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_arbValid) begin
                r_grant  <= w_arbIdx;
                r_araddr <= w_selAddr;
            end
            if (w_release) begin
                r_ptr <= w_nextPtr;
            end
        end
    end

    // Only the granted master ever sees ARREADY/RVALID; data is broadcast to all.
    always_comb begin
        w_nextState = r_state;
        w_release   = 1'b0;
        s_arready   = '0;
        s_rvalid    = '0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        s_rdata     = m_rdata;
        s_rresp     = m_rresp;
        case (r_state)
            IDLE: begin
                if (w_arbValid) begin
                    w_nextState = ADDR;
                end
            end
            ADDR: begin
                m_arvalid          = 1'b1;
                s_arready[r_grant] = m_arready;
                if (m_arready) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_timedOut) begin
                    s_rvalid[r_grant] = 1'b1;
                    s_rdata           = '0;
                    s_rresp           = RRESP_SLVERR;
                    if (s_rready[r_grant]) begin
                        w_nextState = DRAIN;
                    end
                end else begin
                    s_rvalid[r_grant] = m_rvalid;
                    m_rready          = s_rready[r_grant];
                    if (m_rvalid && s_rready[r_grant]) begin
                        w_nextState = IDLE;
                        w_release   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The late slave beat belongs to the abandoned read and is swallowed here.
                m_rready = 1'b1;
                if (m_rvalid) begin
                    w_nextState = IDLE;
                    w_release   = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Directed, scoreboard-driven bench for axil_read_arbiter with two masters.
// Build with AXIL_RD_TIMEOUT_EN defined to also exercise the timeout/DRAIN path.
module tb_axil_read_arbiter;
    import axil_rd_arb_pkg::*;

    localparam int NUM_M  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        int          master;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic                    ACLK = 1'b0;
    logic                    ARESETn;
    logic [NUM_M-1:0]        s_arvalid;
    logic [NUM_M*ADDR_W-1:0] s_araddr;
    logic [NUM_M-1:0]        s_arready;
    logic [NUM_M-1:0]        s_rvalid;
    logic [NUM_M-1:0]        s_rready;
    logic [DATA_W-1:0]       s_rdata;
    logic [1:0]              s_rresp;
    logic                    m_arvalid;
    logic [ADDR_W-1:0]       m_araddr;
    logic                    m_arready;
    logic                    m_rvalid;
    logic                    m_rready;
    logic [DATA_W-1:0]       m_rdata;
    logic [1:0]              m_rresp;

    int   errors = 0;
    int   checks = 0;
    exp_t sbQueue[$];

    axil_read_arbiter #(
        .NUM_M          (NUM_M),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .s_arvalid (s_arvalid),
        .s_araddr  (s_araddr),
        .s_arready (s_arready),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp)
    );

    always #5 ACLK = ~ACLK;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise a master's request and record the response the slave model will return for it.
    task automatic applyStimulus(input int master, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        s_araddr[master*ADDR_W +: ADDR_W] = addr;
        s_arvalid[master] = 1'b1;
        e.master = master;
        e.addr   = addr;
        e.data   = data;
        e.resp   = resp;
        sbQueue.push_back(e);
    endtask

    // Act as the slave for the next expected transaction and check what the masters see.
    task automatic serviceOne(input int arDelay, input int rDelay, input bit keepAr);
        exp_t       e;
        int         waitCnt;
        logic [1:0] oneHot;
        e       = sbQueue.pop_front();
        oneHot  = '0;
        oneHot[e.master] = 1'b1;
        waitCnt = 0;
        while (m_arvalid !== 1'b1 && waitCnt < 20) begin
            @(negedge ACLK);
            waitCnt++;
        end
        checkOutput("m_arvalid_up", m_arvalid, 1);
        checkOutput("m_araddr", m_araddr, e.addr);
        repeat (arDelay) begin
            checkOutput("s_arready_wait", s_arready, 0);
            @(negedge ACLK);
            checkOutput("m_araddr_hold", m_araddr, e.addr);
        end
        m_arready = 1'b1;
        #1;
        checkOutput("s_arready_grant", s_arready, oneHot);
        @(negedge ACLK);
        m_arready = 1'b0;
        if (!keepAr) s_arvalid[e.master] = 1'b0;
        checkOutput("m_arvalid_data", m_arvalid, 0);
        m_rvalid = 1'b1;
        m_rdata  = e.data;
        m_rresp  = e.resp;
        s_rready = '0;
        repeat (rDelay) begin
            #1;
            checkOutput("m_rready_bp", m_rready, 0);
            checkOutput("s_rvalid_bp", s_rvalid, oneHot);
            checkOutput("s_rdata_bp", s_rdata, e.data);
            @(negedge ACLK);
        end
        s_rready[e.master] = 1'b1;
        #1;
        checkOutput("s_rvalid", s_rvalid, oneHot);
        checkOutput("s_rdata", s_rdata, e.data);
        checkOutput("s_rresp", s_rresp, e.resp);
        checkOutput("m_rready", m_rready, 1);
        @(negedge ACLK);
        m_rvalid = 1'b0;
        s_rready = '0;
        m_rdata  = $urandom;
        #1;
        checkOutput("s_rvalid_done", s_rvalid, 0);
    endtask

    initial begin
        ARESETn   = 1'b0;
        s_arvalid = '0;
        s_araddr  = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = RRESP_OKAY;

        // Reset held with both masters requesting.
        applyStimulus(0, 32'h0000_0100, 32'h1111_0000, RRESP_OKAY);
        applyStimulus(1, 32'h0000_0040, 32'hDEAD_BEEF, RRESP_OKAY);
        repeat (3) begin
            @(negedge ACLK);
            checkOutput("rst_s_arready", s_arready, 0);
            checkOutput("rst_s_rvalid", s_rvalid, 0);
            checkOutput("rst_m_arvalid", m_arvalid, 0);
            checkOutput("rst_m_rready", m_rready, 0);
            checkOutput("rst_m_araddr", m_araddr, 0);
        end
        ARESETn = 1'b1;
        #1;
        checkOutput("idle_m_arvalid", m_arvalid, 0);
        $display("[TB] reset released, expecting master 0 then master 1");
        serviceOne(0, 0, 1'b0);
        serviceOne(2, 0, 1'b0);

        // Contention: both masters keep requesting; order must alternate from master 0.
        applyStimulus(0, 32'h0000_1000, 32'hA000_0001, RRESP_OKAY);
        applyStimulus(1, 32'h0000_2000, 32'hB000_0002, RRESP_SLVERR);
        applyStimulus(0, 32'h0000_1000, 32'hA000_0003, RRESP_OKAY);
        applyStimulus(1, 32'h0000_2000, 32'hB000_0004, RRESP_OKAY);
        for (int t = 0; t < 4; t++) begin
            serviceOne(t % 2, 0, 1'b1);
        end
        s_arvalid = '0;
        @(negedge ACLK);

        // Backpressure: granted master withholds RREADY for 5 cycles.
        applyStimulus(0, 32'h0000_0200, 32'hCAFE_F00D, RRESP_OKAY);
        serviceOne(0, 5, 1'b0);
        @(negedge ACLK);

        // Reset while in DATA with a beat pending.
        s_araddr[1*ADDR_W +: ADDR_W] = 32'h0000_0080;
        s_arvalid = 2'b10;
        repeat (2) @(negedge ACLK);
        checkOutput("mid_m_arvalid", m_arvalid, 1);
        m_arready = 1'b1;
        @(negedge ACLK);
        m_arready = 1'b0;
        s_arvalid = '0;
        m_rvalid  = 1'b1;
        m_rdata   = 32'h5555_AAAA;
        #1;
        checkOutput("mid_s_rvalid", s_rvalid, 2'b10);
        #2;
        ARESETn = 1'b0;
        #1;
        checkOutput("abort_s_rvalid", s_rvalid, 0);
        checkOutput("abort_m_rready", m_rready, 0);
        checkOutput("abort_m_arvalid", m_arvalid, 0);
        checkOutput("abort_m_araddr", m_araddr, 0);
        @(negedge ACLK);
        checkOutput("abort_hold_s_rvalid", s_rvalid, 0);
        m_rvalid = 1'b0;
        ARESETn  = 1'b1;
        applyStimulus(1, 32'h0000_0044, 32'h0BAD_CAFE, RRESP_OKAY);
        serviceOne(1, 1, 1'b0);

`ifdef AXIL_RD_TIMEOUT_EN
        // Silent slave: SLVERR after 8 DATA cycles, then the late beat is drained.
        @(negedge ACLK);
        s_araddr[0 +: ADDR_W] = 32'h0000_0300;
        s_arvalid = 2'b01;
        repeat (2) @(negedge ACLK);
        checkOutput("to_m_arvalid", m_arvalid, 1);
        m_arready = 1'b1;
        @(negedge ACLK);
        m_arready = 1'b0;
        s_arvalid = '0;
        m_rdata   = 32'h7777_7777;
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput("to_wait_s_rvalid", s_rvalid, 0);
            @(negedge ACLK);
        end
        #1;
        checkOutput("to_s_rvalid", s_rvalid, 2'b01);
        checkOutput("to_s_rresp", s_rresp, RRESP_SLVERR);
        checkOutput("to_s_rdata", s_rdata, 0);
        checkOutput("to_m_rready", m_rready, 0);
        applyStimulus(1, 32'h0000_0048, 32'h1234_5678, RRESP_OKAY);
        s_rready[0] = 1'b1;
        @(negedge ACLK);
        s_rready = '0;
        #1;
        checkOutput("drain_m_rready", m_rready, 1);
        checkOutput("drain_s_rvalid", s_rvalid, 0);
        checkOutput("drain_s_arready", s_arready, 0);
        checkOutput("drain_m_arvalid", m_arvalid, 0);
        m_rvalid = 1'b1;
        @(negedge ACLK);
        m_rvalid = 1'b0;
        #1;
        checkOutput("post_drain_m_arvalid", m_arvalid, 0);
        serviceOne(0, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
